// File: rtl/renderer_pkg.sv
// Line renderer constants, FSM state type and sizing helper.
package renderer_pkg;

  localparam int unsigned LINE_WIDTH  = 1200;
  localparam int unsigned LINE_COUNT  = 300;
  localparam int unsigned ROM_LATENCY = 1;
  localparam int unsigned WORD_WIDTH  = 32;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StScan,
    StDraw,
    StDrain
  } state_e;

  // Number of clear words needed to cover a line.
  function automatic int unsigned clear_words(input int unsigned width);
    return (width + WORD_WIDTH - 1) / WORD_WIDTH;
  endfunction

endpackage

// File: rtl/runner_pkg.sv
// Sprite slot description shared with the game runner.
package runner_pkg;

  localparam int unsigned RENDER_SLOTS = 32;

  // Sheet rectangle for one sprite; w == 0 or h == 0 marks an empty slot.
  typedef struct packed {
    logic [12:0] x;
    logic [7:0]  y;
    logic [7:0]  w;
    logic [7:0]  h;
  } sprite_t;

endpackage

// File: rtl/line_buffer.sv
// Double line buffer: draw bank is written/cleared, display bank is read.
module line_buffer #(
  parameter int unsigned LINE_WIDTH = 1200,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 38,
  parameter int unsigned WORD_AW    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel_i,
  input  logic               clr_en_i,
  input  logic [WORD_AW-1:0] clr_word_i,
  input  logic               wr_en_i,
  input  logic [10:0]        wr_x_i,
  input  logic [10:0]        rd_x_i,
  output logic               rd_pixel_o
);

  localparam int unsigned PadWidth = NUM_WORDS * WORD_WIDTH;

  // Bank sel_i is displayed, the other bank is drawn into.
  logic [PadWidth-1:0] bank_q [2];
  logic                rd_pixel_q, rd_pixel_d;

  // Buffer storage has no reset; contents are defined by the first clear.
  always_ff @(posedge clk) begin
    if (clr_en_i) bank_q[~sel_i][clr_word_i*WORD_WIDTH +: WORD_WIDTH] <= '0;
    if (wr_en_i)  bank_q[~sel_i][wr_x_i] <= 1'b1;
  end

  // Display read, forced to 0 past the visible line.
  always_comb begin
    rd_pixel_d = 1'b0;
    if (32'(rd_x_i) < LINE_WIDTH) rd_pixel_d = bank_q[sel_i][rd_x_i];
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_pixel_q <= 1'b0;
    else      rd_pixel_q <= rd_pixel_d;
  end

  assign rd_pixel_o = rd_pixel_q;

endmodule

// File: rtl/sprite_line_renderer.sv
// Renders one scanline of sprites into a double-buffered line memory.
module sprite_line_renderer
  import runner_pkg::sprite_t;
#(
  parameter int unsigned RENDER_SLOTS = runner_pkg::RENDER_SLOTS,
  parameter int unsigned LINE_WIDTH   = renderer_pkg::LINE_WIDTH,
  parameter int unsigned LINE_COUNT   = renderer_pkg::LINE_COUNT
) (
  input  logic        clk,
  input  logic        rst,
  input  sprite_t     sprite [RENDER_SLOTS],
  input  logic [10:0] pos    [RENDER_SLOTS][2],
  input  logic        line_start,
  input  logic [8:0]  line_y,
  output logic [12:0] rom_x,
  output logic [7:0]  rom_y,
  output logic        rom_en,
  input  logic        rom_pixel,
  input  logic [10:0] rd_x,
  output logic        rd_pixel,
  output logic        busy,
  output logic        overrun
);

  import renderer_pkg::*;

  localparam int unsigned ClearWords = clear_words(LINE_WIDTH);
  localparam int unsigned ClrAw      = $clog2(ClearWords);
  localparam int unsigned SlotAw     = $clog2(RENDER_SLOTS);

  // Datapath assumes a one-cycle ROM and 9/11-bit line coordinates.
  if (ROM_LATENCY != 1 || LINE_COUNT > 512 || LINE_WIDTH > 2048) begin : gen_bad_cfg
    $error("sprite_line_renderer: unsupported configuration");
  end

  state_e             state_q, state_d;
  logic [SlotAw-1:0]  slot_q, slot_d;
  logic [7:0]         col_q, col_d;
  logic [8:0]         line_y_q, line_y_d;
  logic [ClrAw-1:0]   clr_q, clr_d;
  logic               sel_q, sel_d;
  logic               overrun_q, overrun_d;
  logic               wr_pend_q, wr_pend_d;
  logic [11:0]        wr_x_q, wr_x_d;

  sprite_t            cur;
  logic [10:0]        cur_px, cur_py;
  logic [11:0]        y_line, y_hi, col_x;
  logic [7:0]         row_off;
  logic               hit, last_col, last_slot, wr_en;

  // Live view of the slot currently being scanned or drawn.
  always_comb begin
    cur       = sprite[slot_q];
    cur_px    = pos[slot_q][0];
    cur_py    = pos[slot_q][1];
    y_line    = {3'b000, line_y_q};
    y_hi      = {1'b0, cur_py} + {4'b0000, cur.h};
    hit       = (cur.w != 8'd0) && (cur.h != 8'd0) &&
                ({1'b0, cur_py} <= y_line) && (y_line < y_hi);
    col_x     = {1'b0, cur_px} + {4'b0000, col_q};
    row_off   = line_y_q[7:0] - cur_py[7:0];
    last_col  = ({1'b0, col_q} + 9'd1) >= {1'b0, cur.w};
    last_slot = slot_q == SlotAw'(RENDER_SLOTS - 1);
  end

  // Next-state logic; line_start overrides everything and restarts the line.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    col_d     = col_q;
    line_y_d  = line_y_q;
    clr_d     = clr_q;
    sel_d     = sel_q;
    overrun_d = overrun_q;
    wr_pend_d = 1'b0;
    wr_x_d    = wr_x_q;
    unique case (state_q)
      StIdle: ;
      StClear: begin
        if (clr_q == ClrAw'(ClearWords - 1)) begin
          state_d = StScan;
          slot_d  = '0;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      StScan: begin
        if (hit) begin
          state_d = StDraw;
          col_d   = '0;
        end else if (last_slot) begin
          state_d = StIdle;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      StDraw: begin
        // Remember the target column; the pixel arrives next cycle.
        wr_pend_d = 1'b1;
        wr_x_d    = col_x;
        if (last_col) state_d = StDrain;
        else          col_d   = col_q + 8'd1;
      end
      StDrain: begin
        if (last_slot) begin
          state_d = StIdle;
        end else begin
          state_d = StScan;
          slot_d  = slot_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (line_start) begin
      sel_d     = ~sel_q;
      line_y_d  = line_y;
      state_d   = StClear;
      clr_d     = '0;
      wr_pend_d = 1'b0;
      if (state_q != StIdle) overrun_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      slot_q    <= '0;
      col_q     <= '0;
      line_y_q  <= '0;
      clr_q     <= '0;
      sel_q     <= 1'b0;
      overrun_q <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_x_q    <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      col_q     <= col_d;
      line_y_q  <= line_y_d;
      clr_q     <= clr_d;
      sel_q     <= sel_d;
      overrun_q <= overrun_d;
      wr_pend_q <= wr_pend_d;
      wr_x_q    <= wr_x_d;
    end
  end

  // Outputs; ROM address is held at zero outside DRAW.
  always_comb begin
    busy    = state_q != StIdle;
    overrun = overrun_q;
    rom_en  = state_q == StDraw;
    rom_x   = '0;
    rom_y   = '0;
    if (rom_en) begin
      rom_x = cur.x + {5'b00000, col_q};
      rom_y = cur.y + row_off;
    end
    wr_en = wr_pend_q && rom_pixel && (wr_x_q < 12'(LINE_WIDTH));
  end

  line_buffer #(
    .LINE_WIDTH (LINE_WIDTH),
    .WORD_WIDTH (WORD_WIDTH),
    .NUM_WORDS  (ClearWords),
    .WORD_AW    (ClrAw)
  ) u_line_buffer (
    .clk        (clk),
    .rst        (rst),
    .sel_i      (sel_q),
    .clr_en_i   (state_q == StClear),
    .clr_word_i (clr_q),
    .wr_en_i    (wr_en),
    .wr_x_i     (wr_x_q[10:0]),
    .rd_x_i     (rd_x),
    .rd_pixel_o (rd_pixel)
  );

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Directed bench for sprite_line_renderer with a behavioural sprite ROM.
module tb_sprite_line_renderer;
  import runner_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  sprite_t     sprite [32];
  logic [10:0] pos    [32][2];
  logic        line_start = 1'b0;
  logic [8:0]  line_y = '0;
  logic [12:0] rom_x;
  logic [7:0]  rom_y;
  logic        rom_en;
  logic        rom_pixel;
  logic [10:0] rd_x = '0;
  logic        rd_pixel;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int rom_mode = 0;

  sprite_line_renderer dut (
    .clk        (clk),
    .rst        (rst),
    .sprite     (sprite),
    .pos        (pos),
    .line_start (line_start),
    .line_y     (line_y),
    .rom_x      (rom_x),
    .rom_y      (rom_y),
    .rom_en     (rom_en),
    .rom_pixel  (rom_pixel),
    .rd_x       (rd_x),
    .rd_pixel   (rd_pixel),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Mode 0: all opaque. Mode 1: sheet x<100 opaque on even x, else on odd x.
  function automatic logic rom_bit(input logic [12:0] x);
    if (rom_mode == 0) return 1'b1;
    if (x < 13'd100) return ~x[0];
    return x[0];
  endfunction

  // One-cycle ROM.
  always @(posedge clk) rom_pixel <= rom_en ? rom_bit(rom_x) : 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_slots();
    for (int i = 0; i < 32; i++) begin
      sprite[i] = '0;
      pos[i][0] = '0;
      pos[i][1] = '0;
    end
  endtask

  task automatic start_line(input logic [8:0] y);
    line_y     = y;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic wait_rom(output int n);
    n = 0;
    while (!rom_en && n < 200) begin
      tick();
      n++;
    end
    check("rom_en_timeout", rom_en, 1);
  endtask

  // Swap in an off-screen line so the previous render becomes visible.
  task automatic show_line();
    start_line(9'd400);
    wait_idle();
  endtask

  task automatic read_px(input int x, output logic v);
    rd_x = 11'(x);
    tick();
    v = rd_pixel;
  endtask

  task automatic check_px(input string tag, input int x, input logic exp);
    logic v;
    read_px(x, v);
    check(tag, v, exp);
  endtask

  task automatic count_line(output int n);
    logic v;
    n = 0;
    for (int x = 0; x < 1200; x++) begin
      read_px(x, v);
      if (v) n++;
    end
  endtask

  initial begin
    int n;
    logic saw;
    clear_slots();

    // Reset values
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_rom_en", rom_en, 0);
    check("rst_rom_x", rom_x, 0);
    check("rst_rom_y", rom_y, 0);
    check("rst_rd_pixel", rd_pixel, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b1;
    tick();

    // Single slot hit on its second row
    sprite[0] = '{x: 13'd100, y: 8'd2, w: 8'd4, h: 8'd2};
    pos[0][0] = 11'd10;
    pos[0][1] = 11'd50;
    start_line(9'd51);
    check("t1_busy", busy, 1);
    wait_rom(n);
    check("t1_latency", n, 39);
    for (int c = 0; c < 4; c++) begin
      check("t1_rom_en", rom_en, 1);
      check("t1_rom_x", rom_x, 100 + c);
      check("t1_rom_y", rom_y, 3);
      tick();
    end
    check("t1_drain_rom_en", rom_en, 0);
    wait_idle();
    show_line();
    for (int x = 8; x < 16; x++) check_px("t1_px", x, (x >= 10 && x <= 13));
    count_line(n);
    check("t1_count", n, 4);

    // Line just below the slot: no reads, CLEAR + 32 SCAN cycles
    start_line(9'd52);
    n = 0;
    saw = 1'b0;
    while (busy && n < 500) begin
      if (rom_en) saw = 1'b1;
      tick();
      n++;
    end
    check("t2_busy_cycles", n, 70);
    check("t2_no_rom_en", saw, 0);
    show_line();
    count_line(n);
    check("t2_count", n, 0);

    // Right edge clipping
    clear_slots();
    sprite[0] = '{x: 13'd0, y: 8'd0, w: 8'd4, h: 8'd1};
    pos[0][0] = 11'd1198;
    start_line(9'd0);
    wait_idle();
    show_line();
    check_px("t3_px1197", 1197, 1'b0);
    check_px("t3_px1198", 1198, 1'b1);
    check_px("t3_px1199", 1199, 1'b1);
    check_px("t3_px1200", 1200, 1'b0);
    check_px("t3_px2047", 2047, 1'b0);
    count_line(n);
    check("t3_count", n, 2);

    // Overlapping slots 5 and 29 with complementary patterns
    clear_slots();
    rom_mode = 1;
    sprite[5]  = '{x: 13'd0,   y: 8'd0, w: 8'd4, h: 8'd1};
    sprite[29] = '{x: 13'd200, y: 8'd0, w: 8'd4, h: 8'd1};
    pos[5][0]  = 11'd20;
    pos[5][1]  = 11'd7;
    pos[29][0] = 11'd20;
    pos[29][1] = 11'd7;
    start_line(9'd7);
    wait_idle();
    rom_mode = 0;
    show_line();
    for (int x = 19; x < 25; x++) check_px("t4_px", x, (x >= 20 && x <= 23));
    count_line(n);
    check("t4_count", n, 4);

    // Restart 10 cycles into DRAW
    check("t5_overrun_before", overrun, 0);
    clear_slots();
    sprite[0] = '{x: 13'd100, y: 8'd2, w: 8'd40, h: 8'd2};
    pos[0][0] = 11'd300;
    pos[0][1] = 11'd50;
    start_line(9'd50);
    wait_rom(n);
    repeat (10) tick();
    check("t5_mid_draw", rom_en, 1);
    start_line(9'd51);
    check("t5_overrun", overrun, 1);
    check("t5_busy", busy, 1);
    wait_idle();
    check("t5_overrun_sticky", overrun, 1);
    show_line();
    check_px("t5_px299", 299, 1'b0);
    check_px("t5_px300", 300, 1'b1);
    check_px("t5_px339", 339, 1'b1);
    check_px("t5_px340", 340, 1'b0);
    count_line(n);
    check("t5_count", n, 40);

    // Reset pulse mid-DRAW
    start_line(9'd50);
    wait_rom(n);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("t6_busy", busy, 0);
    check("t6_rom_en", rom_en, 0);
    check("t6_rom_x", rom_x, 0);
    check("t6_rom_y", rom_y, 0);
    check("t6_rd_pixel", rd_pixel, 0);
    check("t6_overrun", overrun, 0);
    rst = 1'b1;
    repeat (5) tick();
    check("t6_idle_busy", busy, 0);
    check("t6_idle_rom_en", rom_en, 0);
    start_line(9'd50);
    wait_idle();
    show_line();
    count_line(n);
    check("t6_count", n, 40);
    check("t6_overrun_after", overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
